// File: rtl/instr_prefetch_if.sv
// Instruction prefetch bus bundle.
// Groups the core-side signals (PC in, Iin/EN_L out) and the instruction
// memory signals (MEM_REQ/MEM_ADDR out, MEM_ACK/MEM_RDATA in).
//   master : used by the prefetch stage (drives Iin, EN_L, MEM_REQ, MEM_ADDR)
//   slave  : used by the core/memory side (drives PC, MEM_ACK, MEM_RDATA)
interface instr_prefetch_if #(
  parameter int AW = 8,
  parameter int IW = 16
) ();
  logic [AW-1:0] PC;
  logic [IW-1:0] Iin;
  logic          EN_L;
  logic          MEM_REQ;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_ACK;
  logic [IW-1:0] MEM_RDATA;

  modport master (
    input  PC, MEM_ACK, MEM_RDATA,
    output Iin, EN_L, MEM_REQ, MEM_ADDR
  );

  modport slave (
    output PC, MEM_ACK, MEM_RDATA,
    input  Iin, EN_L, MEM_REQ, MEM_ADDR
  );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetch stage.
// Prefetches consecutive 16-bit instruction words from a variable-latency
// instruction memory into a small FIFO and serves the core's PC with zero
// latency. EN_L=1 stalls the core until the addressed word is buffered.
// Ports:
//   CLK      : clock, all state changes on the rising edge
//   RESET_L  : synchronous reset, active low
//   bus      : instr_prefetch_if.master (PC, Iin, EN_L, MEM_REQ, MEM_ADDR,
//              MEM_ACK, MEM_RDATA)
//   STALL_CNT, FLUSH_CNT : statistics outputs, only when the macro
//              FETCH_STATS_EN is defined
// Parameters: DEPTH (FIFO entries, power of 2, >= 2), AW, IW.
module instr_prefetch #(
  parameter int DEPTH = 2,
  parameter int AW    = 8,
  parameter int IW    = 16
) (
  input  logic               CLK,
  input  logic               RESET_L,
  instr_prefetch_if.master   bus
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        STALL_CNT,
  output logic [7:0]         FLUSH_CNT
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] head_ptr_reg, head_ptr_next;
  logic [AW-1:0] head_addr_reg, head_addr_next;
  logic [AW-1:0] fetch_addr_reg, fetch_addr_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic          mem_req_reg, mem_req_next;

  // Only data is stored: entry k always holds head_addr + 2k.
  logic [IW-1:0] fifo_data [DEPTH];

  logic [AW-1:0] head_addr_p2;
  logic [AW-1:0] mem_addr_p2;
  logic [AW-1:0] expected_addr;
  logic [PW-1:0] ptr1;
  logic [PW-1:0] wr_ptr;
  logic          has1, has2, hit0, hit1, advance, redirect, push, en_l;

  assign head_addr_p2 = head_addr_reg + AW'(2);
  assign mem_addr_p2  = mem_addr_reg + AW'(2);
  assign ptr1         = head_ptr_reg + PW'(1);
  // Pushes never happen while full, so the slot after the last entry is free.
  assign wr_ptr       = head_ptr_reg + PW'(count_reg);

  assign has1 = (count_reg != '0);
  assign has2 = (count_reg >= CW'(2));
  assign hit0 = has1 && (bus.PC == head_addr_reg);
  assign hit1 = has2 && (bus.PC == head_addr_p2);

  assign en_l      = !(hit0 || hit1);
  assign bus.EN_L  = en_l;
  assign bus.Iin   = hit0 ? fifo_data[head_ptr_reg] :
                     hit1 ? fifo_data[ptr1] : '0;
  assign bus.MEM_REQ  = mem_req_reg;
  assign bus.MEM_ADDR = mem_addr_reg;

  // The core moving one word past the head is the normal sequential case;
  // anything else that differs from the next expected address is a branch.
  assign advance       = has1 && (bus.PC == head_addr_p2);
  assign expected_addr = has1 ? head_addr_reg :
                         (state_reg == BUSY) ? mem_addr_reg : fetch_addr_reg;
  assign redirect      = (bus.PC != expected_addr) && !advance;
  assign push          = (state_reg == BUSY) && bus.MEM_ACK && !redirect;

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    head_ptr_next   = head_ptr_reg;
    head_addr_next  = head_addr_reg;
    fetch_addr_next = fetch_addr_reg;
    mem_addr_next   = mem_addr_reg;
    mem_req_next    = mem_req_reg;

    if (redirect) begin
      count_next      = '0;
      fetch_addr_next = bus.PC;
    end else if (advance) begin
      count_next     = count_reg - CW'(1);
      head_ptr_next  = ptr1;
      head_addr_next = head_addr_p2;
    end

    if (push) begin
      count_next      = count_next + CW'(1);
      fetch_addr_next = mem_addr_p2;
      // An empty FIFO takes its new head address from the returning request.
      if (!has1) head_addr_next = mem_addr_reg;
    end

    case (state_reg)
      IDLE: begin
        if (count_next < CW'(DEPTH)) begin
          mem_req_next  = 1'b1;
          mem_addr_next = redirect ? bus.PC : fetch_addr_reg;
          state_next    = BUSY;
        end
      end
      BUSY: begin
        if (bus.MEM_ACK) begin
          mem_req_next = 1'b0;
          state_next   = IDLE;
        end else if (redirect) begin
          // The request cannot be withdrawn; wait for its data and drop it.
          state_next = DROP;
        end
      end
      DROP: begin
        if (bus.MEM_ACK) begin
          mem_req_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      head_ptr_reg   <= '0;
      head_addr_reg  <= '0;
      fetch_addr_reg <= '0;
      mem_addr_reg   <= '0;
      mem_req_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      head_ptr_reg   <= head_ptr_next;
      head_addr_reg  <= head_addr_next;
      fetch_addr_reg <= fetch_addr_next;
      mem_addr_reg   <= mem_addr_next;
      mem_req_reg    <= mem_req_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET_L && push) fifo_data[wr_ptr] <= bus.MEM_RDATA;
  end

`ifdef FETCH_STATS_EN
  logic [15:0] stall_cnt_reg;
  logic [7:0]  flush_cnt_reg;
  logic        flush_event;

  // A redirect counts only when it throws away buffered or in-flight data.
  assign flush_event = redirect && (has1 || (state_reg == BUSY));

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (en_l && (stall_cnt_reg != '1))        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (flush_event && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + 8'd1;
    end
  end

  assign STALL_CNT = stall_cnt_reg;
  assign FLUSH_CNT = flush_cnt_reg;
`endif
endmodule
